// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port between the load
// unit (port 0) and the store drain (port 1). Optional lock: `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_LEN = 16,
  parameter int DATA_LEN = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [ADDR_LEN-1:0] addr0,
  input  logic [ADDR_LEN-1:0] addr1,
  input  logic [DATA_LEN-1:0] wdata0,
  input  logic [DATA_LEN-1:0] wdata1,
  input  logic                lock0,
  input  logic                lock1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_LEN-1:0] rdata0,
  output logic [DATA_LEN-1:0] rdata1,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [DATA_LEN-1:0] dmem_wdata,
  output logic                dmem_we,
  input  logic [DATA_LEN-1:0] dmem_rdata
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
    $error("dmem_arbiter: MAX_HOLD must be in 1..15");
  end

  logic last_q, last_d;
  logic rsp_vld_q, rsp_vld_d;
  logic rsp_port_q, rsp_port_d;
  logic owner_lock_q;
  logic hold_ok;
  logic last_req;
  logic keep_owner;
  logic win_vld, win_port, win_we;

  assign last_req   = last_q ? req1 : req0;
  assign keep_owner = owner_lock_q && last_req && hold_ok;

`ifdef DMEM_ARB_LOCK_EN
  localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

  logic       owner_lock_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       win_lock;

  function automatic logic [3:0] hold_inc(input logic [3:0] cnt);
    return (cnt >= HoldMax) ? HoldMax : cnt + 4'd1;
  endfunction

  assign hold_ok  = (hold_cnt_q < HoldMax);
  assign win_lock = win_port ? lock1 : lock0;

  // A grant without lock, or a cycle with no grant at all, drops ownership.
  always_comb begin
    owner_lock_d = 1'b0;
    hold_cnt_d   = 4'd0;
    if (win_vld && win_lock) begin
      owner_lock_d = 1'b1;
      hold_cnt_d   = (owner_lock_q && (last_q == win_port)) ? hold_inc(hold_cnt_q) : 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_lock_q <= 1'b0;
      hold_cnt_q   <= 4'd0;
    end else begin
      owner_lock_q <= owner_lock_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end
`else
  logic unused_lock;

  assign owner_lock_q = 1'b0;
  assign hold_ok      = 1'b0;
  assign unused_lock  = lock0 ^ lock1;
`endif

  // Winner selection: locked owner first, then single requester, then round-robin.
  always_comb begin
    win_vld  = 1'b0;
    win_port = 1'b0;
    if (!reset) begin
      if (keep_owner) begin
        win_vld  = 1'b1;
        win_port = last_q;
      end else if (req0 && req1) begin
        win_vld  = 1'b1;
        win_port = ~last_q;
      end else if (req0 || req1) begin
        win_vld  = 1'b1;
        win_port = req1;
      end
    end
  end

  assign win_we     = win_port ? we1 : we0;
  assign gnt0       = win_vld & ~win_port;
  assign gnt1       = win_vld &  win_port;
  assign dmem_addr  = win_port ? addr1  : addr0;
  assign dmem_wdata = win_port ? wdata1 : wdata0;
  assign dmem_we    = win_vld & win_we;

  always_comb begin
    last_d     = last_q;
    rsp_vld_d  = 1'b0;
    rsp_port_d = rsp_port_q;
    if (win_vld) begin
      last_d     = win_port;
      rsp_vld_d  = ~win_we;
      rsp_port_d = win_port;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_port_q <= rsp_port_d;
    end
  end

  // Reset masks a response still in flight from the cycle before it asserted.
  assign rvalid0 = rsp_vld_q & ~reset & ~rsp_port_q;
  assign rvalid1 = rsp_vld_q & ~reset &  rsp_port_q;
  assign rdata0  = dmem_rdata;
  assign rdata1  = dmem_rdata;

endmodule
